// File: rtl/tp_arb_pkg.sv
// Shared types and helpers for the CBUS/PHY memory arbiter.
// Holds the FSM state encoding and the lane mask/extract helpers that map
// a 32-bit CBUS word onto one lane of a wider memory word.
package tp_arb_pkg;

  localparam int unsigned CBUS_DW = 32;
  localparam int unsigned MAX_DW  = 256;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PEND   = 3'd1,
    ST_ACK    = 3'd2,
    ST_RDWAIT = 3'd3,
    ST_RESP   = 3'd4
  } arb_state_e;

  // Write-enable mask with ones only in the selected 32-bit lane of a dw-wide word.
  function automatic logic [MAX_DW-1:0] lane_mask(input int unsigned dw, input logic [2:0] lane);
    logic [MAX_DW-1:0] m;
    int unsigned       base;
    m    = '0;
    base = CBUS_DW * 32'(lane);
    if (base < dw) m[base +: CBUS_DW] = '1;
    return m;
  endfunction

  // Pick the selected 32-bit lane out of a (zero-extended) memory word.
  function automatic logic [CBUS_DW-1:0] lane_extract(input logic [MAX_DW-1:0] data, input logic [2:0] lane);
    int unsigned base;
    base = CBUS_DW * 32'(lane);
    return data[base +: CBUS_DW];
  endfunction

endpackage

// File: rtl/tp_arb_starve_cnt.sv
// Starvation counter for the CBUS request: counts PEND cycles in which the
// PHY blocks the CBUS and raises force once the limit has been reached.
// Only instantiated when TP_ARB_STARVE_GUARD_EN is defined.
module tp_arb_starve_cnt #(
  parameter int STARVE_MAX = 15
) (
  input  logic clk,
  input  logic sreset,
  input  logic pend_i,
  input  logic blocked_i,
  input  logic grant_i,
  output logic force_o
);

  localparam logic [7:0] LIMIT = 8'(STARVE_MAX);

  logic [7:0] cnt_q, cnt_d;

  // Clear on grant, count blocked cycles, saturate at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (grant_i) begin
      cnt_d = '0;
    end else if (blocked_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (sreset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign force_o = pend_i && (cnt_q == LIMIT);

endmodule

// File: rtl/tp_cbus_mem_arbiter.sv
// Arbiter between the PHY datapath and 32-bit CBUS register accesses onto a
// two-port (1W/1R) memory. PHY keeps priority; CBUS writes and reads use the
// ports independently. Optional starvation guard: TP_ARB_STARVE_GUARD_EN.
module tp_cbus_mem_arbiter
  import tp_arb_pkg::*;
#(
  parameter  int DW         = 64,
  parameter  int AW         = 10,
  parameter  int RD_LAT     = 1,
  parameter  int STARVE_MAX = 15,
  localparam int LW         = $clog2(DW/32),
  localparam int CBUS_AW    = AW + LW
) (
  input  logic               clk,
  input  logic               sreset,
  input  logic               cbus_req,
  input  logic               cbus_cmd,
  input  logic [CBUS_AW-1:0] cbus_addr,
  input  logic [31:0]        cbus_wdata,
  output logic               cbus_busy,
  output logic               cbus_waccept,
  output logic               cbus_rresp,
  output logic [31:0]        cbus_rddata,
  input  logic [AW-1:0]      phy_wr_addr,
  input  logic [DW-1:0]      phy_wr_data,
  input  logic [DW-1:0]      phy_wr_mask,
  input  logic               phy_wr_me_en,
  input  logic [AW-1:0]      phy_rd_addr,
  input  logic               phy_rd_me_en,
  output logic               phy_wr_stall,
  output logic               phy_rd_stall,
  output logic [AW-1:0]      mem_wr_addr,
  output logic [DW-1:0]      mem_wr_data,
  output logic [DW-1:0]      mem_wr_mask,
  output logic               mem_wr_me_en,
  output logic [AW-1:0]      mem_rd_addr,
  output logic               mem_rd_me_en,
  input  logic [DW-1:0]      mem_rd_data
);

  arb_state_e         state_q, state_d;
  logic               cmd_q, cmd_d;
  logic [CBUS_AW-1:0] addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [1:0]         lat_q, lat_d;
  logic [31:0]        rddata_q, rddata_d;

  logic [AW-1:0] word;
  logic [2:0]    lane;
  logic          in_pend;
  logic          force_grant;
  logic          wr_gnt;
  logic          rd_gnt;

  assign word = addr_q[CBUS_AW-1:LW];

  generate
    if (LW > 0) begin : g_lane
      assign lane = 3'(addr_q[LW-1:0]);
    end else begin : g_nolane
      assign lane = 3'd0;
    end
  endgenerate

  assign in_pend = (state_q == ST_PEND);
  assign wr_gnt  = in_pend &&  cmd_q && (!phy_wr_me_en || force_grant);
  assign rd_gnt  = in_pend && !cmd_q && (!phy_rd_me_en || force_grant);

`ifdef TP_ARB_STARVE_GUARD_EN
  tp_arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk       (clk),
    .sreset    (sreset),
    .pend_i    (in_pend),
    .blocked_i (in_pend && !(wr_gnt || rd_gnt)),
    .grant_i   (wr_gnt || rd_gnt),
    .force_o   (force_grant)
  );
  // A forced grant rejects whatever the PHY presents on that port this cycle.
  assign phy_wr_stall = wr_gnt && force_grant && phy_wr_me_en;
  assign phy_rd_stall = rd_gnt && force_grant && phy_rd_me_en;
`else
  assign force_grant  = 1'b0;
  assign phy_wr_stall = 1'b0;
  assign phy_rd_stall = 1'b0;
`endif

  // Request FSM: capture in IDLE, arbitrate in PEND, count read latency, pulse response.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    lat_d    = lat_q;
    rddata_d = rddata_q;
    case (state_q)
      ST_IDLE: begin
        if (cbus_req) begin
          cmd_d   = cbus_cmd;
          addr_d  = cbus_addr;
          wdata_d = cbus_wdata;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (wr_gnt) begin
          state_d = ST_ACK;
        end else if (rd_gnt) begin
          lat_d   = 2'(RD_LAT - 1);
          state_d = ST_RDWAIT;
        end
      end
      ST_ACK: state_d = ST_IDLE;
      ST_RDWAIT: begin
        if (lat_q == 2'd0) begin
          rddata_d = lane_extract(MAX_DW'(mem_rd_data), lane);
          state_d  = ST_RESP;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, holding register and read-data register.
  always_ff @(posedge clk) begin
    if (sreset) begin
      state_q  <= ST_IDLE;
      cmd_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      lat_q    <= '0;
      rddata_q <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      lat_q    <= lat_d;
      rddata_q <= rddata_d;
    end
  end

  assign cbus_busy    = (state_q != ST_IDLE);
  assign cbus_waccept = (state_q == ST_ACK);
  assign cbus_rresp   = (state_q == ST_RESP);
  assign cbus_rddata  = rddata_q;

  assign mem_wr_me_en = wr_gnt ? 1'b1                       : phy_wr_me_en;
  assign mem_wr_addr  = wr_gnt ? word                       : phy_wr_addr;
  assign mem_wr_data  = wr_gnt ? {(DW/32){wdata_q}}         : phy_wr_data;
  assign mem_wr_mask  = wr_gnt ? DW'(lane_mask(DW, lane))   : phy_wr_mask;
  assign mem_rd_me_en = rd_gnt ? 1'b1                       : phy_rd_me_en;
  assign mem_rd_addr  = rd_gnt ? word                       : phy_rd_addr;

endmodule

// File: doc/tp_cbus_mem_arbiter.md
# tp_cbus_mem_arbiter

Parametrised successor to the two-port memory arbiter. It sits between the PHY datapath, the CBUS slave interface and one two-port (1W/1R) memory wrapper. It multiplexes 32-bit CBUS register accesses onto a memory of any 32-bit-multiple width. PHY traffic keeps priority, but an optional starvation guard bounds CBUS latency, and the block handles configurable memory read latency with a registered, held read-data return.

## Interface

Parameters:
- DW, 64: memory data width; multiple of 32, 32..256.
- AW, 10: memory address width.
- RD_LAT, 1: memory read latency in cycles, 1..3.
- STARVE_MAX, 15: blocked-cycle limit before a forced CBUS grant; 1..255.
- Derived (localparam): LW = $clog2(DW/32), the lane-select width (0 when DW=32); CBUS_AW = AW+LW.

Ports:
- clk  in  1  single clock.
- sreset  in  1  synchronous, active-high reset.
- cbus_req  in  1  request strobe; sampled only when cbus_busy=0.
- cbus_cmd  in  1  1=write, 0=read.
- cbus_addr  in  CBUS_AW  {word address, lane}; lane in LSBs.
- cbus_wdata  in  32  write data.
- cbus_busy  out  1  request pending/in flight.
- cbus_waccept  out  1  one-cycle write-done pulse.
- cbus_rresp  out  1  one-cycle read-valid pulse.
- cbus_rddata  out  32  read data; held until the next response.
- phy_wr_addr / phy_wr_data / phy_wr_mask / phy_wr_me_en  in  AW/DW/DW/1  PHY write port.
- phy_rd_addr / phy_rd_me_en  in  AW/1  PHY read port.
- phy_wr_stall, phy_rd_stall  out  1  PHY op rejected this cycle; the PHY must hold it.
- mem_wr_addr / mem_wr_data / mem_wr_mask / mem_wr_me_en  out  AW/DW/DW/1  to memory.
- mem_rd_addr / mem_rd_me_en  out  AW/1  to memory.
- mem_rd_data  in  DW  from memory, RD_LAT cycles after mem_rd_me_en.

## Operation

- The FSM has five states: IDLE, PEND, ACK, RDWAIT and RESP.
- **IDLE**
  - On cbus_req, capture cmd, addr and wdata into the holding register.
  - Go to PEND; cbus_busy=1 from the next cycle.
- **PEND**
  - A write is granted when phy_wr_me_en=0 or force=1.
  - A read is granted when phy_rd_me_en=0 or force=1.
  - The write and read ports arbitrate independently; a CBUS write never blocks a PHY read, and vice versa.
- **Write grant** (combinational from the holding register):
  - mem_wr_me_en=1 and mem_wr_addr=addr[CBUS_AW-1:LW].
  - mem_wr_data is wdata replicated DW/32 times.
  - mem_wr_mask has 1s only in bits [32*lane+31:32*lane] (1 = write bit).
  - Next state ACK.
- **ACK**: cbus_waccept=1 for one cycle, then IDLE.
- **Read grant**:
  - mem_rd_me_en=1 and mem_rd_addr=word address.
  - Next state RDWAIT, which counts RD_LAT cycles.
  - When the count expires, register mem_rd_data[32*lane+31:32*lane] into cbus_rddata and go to RESP.
- **RESP**: cbus_rresp=1 for one cycle, then IDLE.
- **Ungranted cycles**: the mem_* outputs pass the PHY signals through unchanged.
- **cbus_req while busy**: ignored. This is a protocol violation and must not corrupt the holding register.
- **Same-address conflicts**: PHY write and CBUS read (or vice versa) to the same address in the same cycle are passed through. Read-during-write semantics are those of the memory.

## Timing

- **Reset values**:
  - Every output is 0 (cbus_rddata=0).
  - The FSM is in IDLE, the starvation counter is 0 and the holding register is cleared.
- **Reset mid-operation**:
  - The pending or in-flight request is dropped, with no waccept/rresp.
  - Late mem_rd_data is ignored.
- **Write, unblocked**: cbus_req at cycle T, grant at T+1, cbus_waccept at T+2, cbus_busy low at T+3.
- **Read, unblocked**: grant at T+1, mem_rd_data valid at T+1+RD_LAT, cbus_rresp and cbus_rddata at T+2+RD_LAT.
- **Blocked PEND**: each blocked cycle adds exactly one cycle to the latency.
- **Back-to-back**: a new cbus_req is accepted in the first cycle cbus_busy=0.

## Configuration

- Macro: TP_ARB_STARVE_GUARD_EN.
- **Defined**:
  - A counter increments on each PEND cycle in which the CBUS request is blocked by the PHY.
  - When the counter equals STARVE_MAX, force=1 on the next PEND cycle. The CBUS wins, and phy_wr_stall (write) or phy_rd_stall (read) is 1 for that cycle only.
  - The counter clears on grant or reset; it saturates and never wraps.
- **Undefined**:
  - Strict PHY priority; force=0 and both stall outputs are tied to 0.
  - No counter logic is generated, and the CBUS may wait indefinitely.

## Structure

- **Package tp_arb_pkg**:
  - The FSM state enum.
  - CBUS_DW=32.
  - Lane-mask and lane-extract functions, parametrised on DW.
- **Sub-module tp_arb_starve_cnt**: counter plus force flag, instantiated only under TP_ARB_STARVE_GUARD_EN.

## Test plan

- Reset with outputs checked, then with DW=64, CBUS write addr={0x005,1}, data 0xA5A5_0001 and PHY idle:
  - mem_wr_mask=0xFFFFFFFF_00000000 and mem_wr_addr=0x005 at T+1.
  - cbus_waccept at T+2.
- CBUS read of the same lane, RD_LAT=2, memory returning 0x1234_5678_A5A5_0001 → cbus_rresp at T+4 with cbus_rddata=0x1234_5678, held afterwards.
- phy_rd_me_en held high for 5 cycles during a CBUS read, macro undefined → grant in the first idle cycle, no stalls, phy_wr path unaffected.
- Macro defined, STARVE_MAX=3, PHY write continuously busy:
  - Forced grant on the 4th PEND cycle.
  - phy_wr_stall=1 for exactly one cycle.
  - CBUS data is written and the PHY op completes the next cycle.
- cbus_req re-asserted while busy with different data → ignored; the original data is written.
- sreset asserted during RDWAIT → no cbus_rresp; cbus_rddata=0 and cbus_busy=0 in the cycle after reset.
